// File: rtl/bp_be_pkg.sv
// Shared backend writeback types: FIFO entry layout, starvation counter width and
// per-configuration register/data width lookup.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_inv_cfg,
        e_bp_default_cfg
    } bp_params_e;

    localparam int reg_addr_width_gp   = 5;
    localparam int dword_width_gp      = 64;
    localparam int starve_cnt_width_gp = 8;

    typedef struct packed {
        logic [reg_addr_width_gp-1:0] addr;
        logic [dword_width_gp-1:0]    data;
    } wb_entry_s;

    // Every configuration currently shares the RV64 integer register file shape.
    function automatic int bp_reg_addr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return reg_addr_width_gp;
            default:          return reg_addr_width_gp;
        endcase
    endfunction

    function automatic int bp_dword_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return dword_width_gp;
            default:          return dword_width_gp;
        endcase
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small in-order FIFO with valid/ready enqueue and valid/yumi dequeue.
// ready_o comes straight from a flop and is held low during reset.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);
    localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                ready_q, ready_d;
    logic                push, pop;

    always_comb begin
        push    = v_i & ready_q;
        pop     = yumi_i & (count_q != '0);
        mem_d   = mem_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = (wptr_q == last_lp) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == last_lp) ? '0 : rptr_q + 1'b1;
        end
        if (push & ~pop) count_d = count_q + 1'b1;
        else if (pop & ~push) count_d = count_q - 1'b1;
        ready_d = (count_d != full_lp);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ready_q <= ready_d;
            mem_q   <= mem_d;
        end
    end

    assign ready_o = ready_q;
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];

endmodule

// File: rtl/bp_be_wb_arbiter.sv
// Integer register-file writeback arbiter: pipe results win, long-latency results
// queue in a 2-entry FIFO. Define BP_BE_WB_BYPASS_EN to let an isolated long result
// write in its acceptance cycle.
module bp_be_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p    = e_bp_inv_cfg,
    parameter int         starve_limit_p = 8,
    localparam int reg_addr_width_p = bp_reg_addr_width(bp_params_p),
    localparam int dword_width_p    = bp_dword_width(bp_params_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        pipe_v_i,
    input  logic [reg_addr_width_p-1:0] pipe_addr_i,
    input  logic [dword_width_p-1:0]    pipe_data_i,
    input  logic                        long_v_i,
    input  logic [reg_addr_width_p-1:0] long_addr_i,
    input  logic [dword_width_p-1:0]    long_data_i,
    output logic                        long_ready_o,
    output logic                        rd_w_v_o,
    output logic [reg_addr_width_p-1:0] rd_addr_o,
    output logic [dword_width_p-1:0]    rd_data_o,
    output logic                        pipe_stall_o
);

    localparam logic [starve_cnt_width_gp-1:0] starve_limit_lp = starve_cnt_width_gp'(starve_limit_p);

    wb_entry_s long_entry, head_entry, wr_entry;
    logic      head_v, head_yumi, push_v, sel_v, sel_head, sel_byp;
    logic [starve_cnt_width_gp-1:0] starve_q, starve_d;

    assign long_entry = '{addr: long_addr_i, data: long_data_i};

    always_comb begin
        sel_head = ~pipe_v_i & head_v;
`ifdef BP_BE_WB_BYPASS_EN
        sel_byp  = ~pipe_v_i & ~head_v & long_v_i & long_ready_o;
`else
        sel_byp  = 1'b0;
`endif
        sel_v    = pipe_v_i | sel_head | sel_byp;
        wr_entry = long_entry;
        if (pipe_v_i)    wr_entry = '{addr: pipe_addr_i, data: pipe_data_i};
        else if (head_v) wr_entry = head_entry;
        head_yumi = sel_head;
        push_v    = long_v_i & long_ready_o & ~sel_byp;
    end

    bsg_fifo_1r1w_small #(
        .width_p ($bits(wb_entry_s)),
        .els_p   (2)
    ) wb_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (push_v),
        .ready_o (long_ready_o),
        .data_i  (long_entry),
        .v_o     (head_v),
        .data_o  (head_entry),
        .yumi_i  (head_yumi)
    );

    // Counts how long the head has been waiting behind pipe writes; saturates.
    always_comb begin
        starve_d = starve_q;
        if (~head_v | head_yumi)  starve_d = '0;
        else if (starve_q != '1)  starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) starve_q <= '0;
        else          starve_q <= starve_d;
    end

    // x0 writes are consumed silently; reset masks a pipe write that is still asserted.
    assign rd_w_v_o     = sel_v & (wr_entry.addr != '0) & reset_i;
    assign rd_addr_o    = wr_entry.addr;
    assign rd_data_o    = wr_entry.data;
    assign pipe_stall_o = (starve_q >= starve_limit_lp);

endmodule

// File: tb/tb_bp_be_wb_arbiter.sv
// Randomized and directed bench for bp_be_wb_arbiter against a queue-based model.
// Honors BP_BE_WB_BYPASS_EN the same way the design does.
module tb_bp_be_wb_arbiter;
    import bp_be_pkg::*;

    localparam int AW  = reg_addr_width_gp;
    localparam int DW  = dword_width_gp;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pipe_v = 1'b0;
    logic [AW-1:0] pipe_a = '0;
    logic [DW-1:0] pipe_d = '0;
    logic          long_v = 1'b0;
    logic [AW-1:0] long_a = '0;
    logic [DW-1:0] long_d = '0;
    logic          long_ready, rd_w_v, pipe_stall;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    bp_be_wb_arbiter #(
        .bp_params_p    (e_bp_inv_cfg),
        .starve_limit_p (LIM)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst_n),
        .pipe_v_i     (pipe_v),
        .pipe_addr_i  (pipe_a),
        .pipe_data_i  (pipe_d),
        .long_v_i     (long_v),
        .long_addr_i  (long_a),
        .long_data_i  (long_d),
        .long_ready_o (long_ready),
        .rd_w_v_o     (rd_w_v),
        .rd_addr_o    (rd_addr),
        .rd_data_o    (rd_data),
        .pipe_stall_o (pipe_stall)
    );

    // Reference model: pending long results in arrival order, head wait time, and
    // whether a clock edge has been seen since reset released.
    wb_entry_s     q[$];
    int            starve = 0;
    bit            armed = 1'b0;
    bit            exp_rdy, exp_stall, exp_byp, exp_sel, exp_v;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    int            errors = 0;
    int            checks = 0;

    task automatic drive(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        pipe_v = pv; pipe_a = pa; pipe_d = pd;
        long_v = lv; long_a = la; long_d = ld;
        #1;
        exp_rdy   = rst_n && armed && (q.size() < 2);
        exp_stall = rst_n && (starve >= LIM);
        exp_byp   = 1'b0;
        exp_sel   = 1'b0;
        exp_a     = '0;
        exp_d     = '0;
        if (rst_n) begin
            if (pv) begin
                exp_sel = 1'b1; exp_a = pa; exp_d = pd;
            end else if (q.size() > 0) begin
                exp_sel = 1'b1; exp_a = q[0].addr; exp_d = q[0].data;
            end
`ifdef BP_BE_WB_BYPASS_EN
            else if (lv && exp_rdy) begin
                exp_sel = 1'b1; exp_byp = 1'b1; exp_a = la; exp_d = ld;
            end
`endif
        end
        exp_v = exp_sel && (exp_a != '0);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        bit was_empty, pop, acc;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            starve = 0;
            armed  = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            pop       = !pipe_v && !was_empty;
            acc       = long_v && exp_rdy && !exp_byp;
            if (was_empty || pop) starve = 0;
            else if (starve < 255) starve++;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{addr: long_a, data: long_d});
            armed = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 5'd9, 64'h1, 1'b1, 5'd2, 64'h2);
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL reset_wv: got %0b want 0", rd_w_v); end
        checks++; if (long_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", long_ready); end
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", pipe_stall); end
        repeat (3) tick();
        rst_n = 1'b1;
        idle();
        checks++; if (long_ready !== 1'b0) begin errors++; $display("FAIL release_ready_pre_edge: got %0b want 0", long_ready); end
        tick();
        idle();
        checks++; if (long_ready !== 1'b1) begin errors++; $display("FAIL first_cycle_ready: got %0b want 1", long_ready); end
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL idle_wv: got %0b want 0", rd_w_v); end
        tick();
    endtask

    task automatic test_pipe_only();
        drive(1'b1, 5'd5, 64'hAA, 1'b0, '0, '0);
        checks++; if (rd_w_v !== 1'b1) begin errors++; $display("FAIL pipe_wv: got %0b want 1", rd_w_v); end
        checks++; if (rd_addr !== 5'd5) begin errors++; $display("FAIL pipe_addr: got %0d want 5", rd_addr); end
        checks++; if (rd_data !== 64'hAA) begin errors++; $display("FAIL pipe_data: got %0h want aa", rd_data); end
        tick();
    endtask

    task automatic test_collision();
        drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 64'h77);
        checks++; if (rd_addr !== 5'd3 || rd_w_v !== 1'b1) begin errors++; $display("FAIL coll_c0: got v=%0b a=%0d want v=1 a=3", rd_w_v, rd_addr); end
        checks++; if (long_ready !== 1'b1) begin errors++; $display("FAIL coll_ready: got %0b want 1", long_ready); end
        tick();
        idle();
        checks++; if (rd_w_v !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 64'h77) begin errors++; $display("FAIL coll_c1: got v=%0b a=%0d d=%0h want v=1 a=7 d=77", rd_w_v, rd_addr, rd_data); end
        tick();
        idle();
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL coll_c2: got %0b want 0", rd_w_v); end
        tick();
    endtask

    task automatic test_full();
        drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd10, 64'hA0);
        checks++; if (long_ready !== 1'b1) begin errors++; $display("FAIL full_c0_ready: got %0b want 1", long_ready); end
        tick();
        drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd11, 64'hB0);
        checks++; if (long_ready !== 1'b1) begin errors++; $display("FAIL full_c1_ready: got %0b want 1", long_ready); end
        tick();
        for (int c = 2; c < 4; c++) begin
            drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd12, 64'hC0);
            checks++; if (long_ready !== 1'b0) begin errors++; $display("FAIL full_c%0d_ready: got %0b want 0", c, long_ready); end
            checks++; if (rd_w_v !== 1'b1 || rd_addr !== 5'd1) begin errors++; $display("FAIL full_c%0d_pipe: got v=%0b a=%0d want v=1 a=1", c, rd_w_v, rd_addr); end
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 5'd12, 64'hC0);
        checks++; if (rd_addr !== 5'd10 || rd_data !== 64'hA0 || long_ready !== 1'b0) begin errors++; $display("FAIL full_c4: got a=%0d d=%0h r=%0b want a=10 d=a0 r=0", rd_addr, rd_data, long_ready); end
        tick();
        drive(1'b0, '0, '0, 1'b1, 5'd12, 64'hC0);
        checks++; if (rd_addr !== 5'd11 || rd_data !== 64'hB0 || long_ready !== 1'b1) begin errors++; $display("FAIL full_c5: got a=%0d d=%0h r=%0b want a=11 d=b0 r=1", rd_addr, rd_data, long_ready); end
        tick();
        idle();
        checks++; if (rd_w_v !== 1'b1 || rd_addr !== 5'd12 || rd_data !== 64'hC0) begin errors++; $display("FAIL full_c6: got v=%0b a=%0d d=%0h want v=1 a=12 d=c0", rd_w_v, rd_addr, rd_data); end
        tick();
        idle();
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL full_c7: got %0b want 0", rd_w_v); end
        tick();
    endtask

    task automatic test_starvation();
        drive(1'b1, 5'd2, 64'h2, 1'b1, 5'd9, 64'h99);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 5'd2, 64'h2, 1'b0, '0, '0);
            checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_c%0d: got %0b want 0", c, pipe_stall); end
            tick();
        end
        idle();
        checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_rise: got %0b want 1", pipe_stall); end
        checks++; if (rd_w_v !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 64'h99) begin errors++; $display("FAIL starve_head: got v=%0b a=%0d d=%0h want v=1 a=9 d=99", rd_w_v, rd_addr, rd_data); end
        tick();
        idle();
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_fall: got %0b want 0", pipe_stall); end
        tick();
    endtask

    task automatic test_x0();
        drive(1'b0, '0, '0, 1'b1, 5'd0, 64'hFF);
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL x0_c0: got %0b want 0", rd_w_v); end
        tick();
        idle();
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL x0_c1: got %0b want 0", rd_w_v); end
        tick();
        drive(1'b0, '0, '0, 1'b1, 5'd4, 64'h44);
`ifdef BP_BE_WB_BYPASS_EN
        checks++; if (rd_w_v !== 1'b1 || rd_addr !== 5'd4) begin errors++; $display("FAIL x0_follow: got v=%0b a=%0d want v=1 a=4", rd_w_v, rd_addr); end
`else
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL x0_follow: got %0b want 0", rd_w_v); end
`endif
        tick();
        idle();
`ifdef BP_BE_WB_BYPASS_EN
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL x0_after: got %0b want 0", rd_w_v); end
`else
        checks++; if (rd_w_v !== 1'b1 || rd_addr !== 5'd4 || rd_data !== 64'h44) begin errors++; $display("FAIL x0_after: got v=%0b a=%0d d=%0h want v=1 a=4 d=44", rd_w_v, rd_addr, rd_data); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd20, 64'h20);
        tick();
        drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd21, 64'h21);
        tick();
        drive(1'b1, 5'd1, 64'h11, 1'b0, '0, '0);
        checks++; if (long_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: got %0b want 0", long_ready); end
        tick();
        rst_n = 1'b0;
        drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd22, 64'h22);
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL rmid_wv0: got %0b want 0", rd_w_v); end
        tick();
        idle();
        checks++; if (rd_w_v !== 1'b0 || long_ready !== 1'b0) begin errors++; $display("FAIL rmid_wv1: got v=%0b r=%0b want v=0 r=0", rd_w_v, long_ready); end
        tick();
        rst_n = 1'b1;
        idle();
        tick();
        idle();
        checks++; if (rd_w_v !== 1'b0 || long_ready !== 1'b1) begin errors++; $display("FAIL rmid_release: got v=%0b r=%0b want v=0 r=1", rd_w_v, long_ready); end
        tick();
        drive(1'b0, '0, '0, 1'b1, 5'd6, 64'h66);
`ifdef BP_BE_WB_BYPASS_EN
        checks++; if (rd_w_v !== 1'b1 || rd_addr !== 5'd6 || rd_data !== 64'h66) begin errors++; $display("FAIL rmid_byp: got v=%0b a=%0d want v=1 a=6", rd_w_v, rd_addr); end
`else
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL rmid_long_c0: got %0b want 0", rd_w_v); end
`endif
        tick();
        idle();
`ifdef BP_BE_WB_BYPASS_EN
        checks++; if (rd_w_v !== 1'b0) begin errors++; $display("FAIL rmid_long_c1: got %0b want 0", rd_w_v); end
`else
        checks++; if (rd_w_v !== 1'b1 || rd_addr !== 5'd6 || rd_data !== 64'h66) begin errors++; $display("FAIL rmid_long_c1: got v=%0b a=%0d want v=1 a=6", rd_w_v, rd_addr); end
`endif
        tick();
    endtask

    task automatic test_random();
        int            pct [4] = '{90, 50, 20, 70};
        logic          lv = 1'b0;
        logic [AW-1:0] la = '0;
        logic [DW-1:0] ld = '0;
        logic          pv;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        bit            held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            pv = ($urandom_range(0, 99) < pct[n / 100]);
            pa = AW'($urandom_range(0, 31));
            pd = {$urandom, $urandom};
            if (!held) begin
                lv = ($urandom_range(0, 2) == 0);
                la = AW'($urandom_range(0, 31));
                ld = {$urandom, $urandom};
            end
            drive(pv, pa, pd, lv, la, ld);
            held = lv && !exp_rdy;
            checks++; if (rd_w_v !== exp_v) begin errors++; $display("FAIL rand_wv@%0d: got %0b want %0b", n, rd_w_v, exp_v); end
            checks++; if (long_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready@%0d: got %0b want %0b", n, long_ready, exp_rdy); end
            checks++; if (pipe_stall !== exp_stall) begin errors++; $display("FAIL rand_stall@%0d: got %0b want %0b", n, pipe_stall, exp_stall); end
            if (exp_v) begin
                checks++; if (rd_addr !== exp_a || rd_data !== exp_d) begin errors++; $display("FAIL rand_wr@%0d: got a=%0d d=%0h want a=%0d d=%0h", n, rd_addr, rd_data, exp_a, exp_d); end
            end
            tick();
        end
        idle();
        repeat (4) tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pipe_only();
        test_collision();
        test_full();
        test_starvation();
        test_x0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
